// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned PH_W    = $clog2(OS_RATE);

  localparam logic [PH_W-1:0] SAMPLE_PH = PH_W'(7);
  localparam logic [PH_W-1:0] LAST_PH   = PH_W'(15);

endpackage

// File: rtl/uart_baud_tick.sv
// Baud 16x tick generator: one-cycle tick every div+1 clocks, held off while clr.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 12
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] tick_cnt;

  // >= lets a divider lowered mid-count take effect at once
  assign tick_c = !clr && (tick_cnt >= div);

  // Free-running counter, restarted on every tick or while cleared
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (clr || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver with single-entry valid/ready holding register.
module uart_rx_os16
  import uart_rx_pkg::*;
#(
  parameter int unsigned DIV_W  = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              cfg_rx_enb,
  input  logic [DIV_W-1:0]  cfg_baud_16x,
  input  logic              cfg_pen,
  input  logic              cfg_epar,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              err_frame,
  output logic              err_parity,
  output logic              err_overrun
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        rxd_sync;
  logic [PH_W-1:0]   phase;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_err;

  logic tick_c;
  logic rx_s_c;
  logic fall_c;
  logic mid_c;
  logic end_c;
  logic shift_c;
  logic par_chk_c;
  logic bit_inc_c;
  logic load_c;
  logic fe_c;
  logic pe_c;
  logic ov_c;

  assign rx_s_c = rxd_sync[1];
  assign fall_c = rxd_sync[2] & ~rxd_sync[1];
  assign mid_c  = tick_c && (phase == SAMPLE_PH);
  assign end_c  = tick_c && (phase == LAST_PH);

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .mclk    (mclk),
    .reset_n (reset_n),
    .clr     (state == IDLE),
    .div     (cfg_baud_16x),
    .tick_c  (tick_c)
  );

  // State register
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    shift_c   = 1'b0;
    par_chk_c = 1'b0;
    bit_inc_c = 1'b0;
    load_c    = 1'b0;
    fe_c      = 1'b0;
    pe_c      = 1'b0;
    ov_c      = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_rx_enb && fall_c) state_nxt = START;
      end
      START: begin
        if (mid_c && rx_s_c) state_nxt = IDLE;
        else if (end_c)      state_nxt = DATA;
      end
      DATA: begin
        shift_c = mid_c;
        if (end_c) begin
          if (bit_cnt == BIT_W'(DATA_W - 1)) state_nxt = cfg_pen ? PARITY : STOP;
          else                               bit_inc_c = 1'b1;
        end
      end
      PARITY: begin
        par_chk_c = mid_c;
        if (end_c) state_nxt = STOP;
      end
      STOP: begin
        if (mid_c) begin
          state_nxt = IDLE;
          if (!rx_s_c)                  fe_c   = 1'b1;
          else if (par_err)             pe_c   = 1'b1;
          else if (rx_valid && !rx_ready) ov_c = 1'b1;
          else                          load_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Disable abandons any partial frame without reporting
    if (!cfg_rx_enb) begin
      state_nxt = IDLE;
      shift_c   = 1'b0;
      par_chk_c = 1'b0;
      bit_inc_c = 1'b0;
      load_c    = 1'b0;
      fe_c      = 1'b0;
      pe_c      = 1'b0;
      ov_c      = 1'b0;
    end
  end

  // Line synchroniser, oversampling counters and shift register
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      rxd_sync <= 3'b111;
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
    end else begin
      rxd_sync <= {rxd_sync[1:0], rxd};
      if (state == IDLE) begin
        phase   <= '0;
        bit_cnt <= '0;
        par_err <= 1'b0;
      end else begin
        if (tick_c)    phase   <= phase + PH_W'(1);
        if (bit_inc_c) bit_cnt <= bit_cnt + BIT_W'(1);
        if (par_chk_c) par_err <= rx_s_c != ((^shreg) ^ ~cfg_epar);
      end
      if (shift_c) shreg <= {rx_s_c, shreg[DATA_W-1:1]};
    end
  end

  // Holding register, handshake and error pulses
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (load_c) rx_data <= shreg;
      rx_valid    <= load_c | (rx_valid & ~rx_ready);
      err_frame   <= fe_c;
      err_parity  <= pe_c;
      err_overrun <= ov_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: frame table plus hand-written corner sequences.
module tb_uart_rx_os16;

  localparam int unsigned DIV_W  = 12;
  localparam int unsigned DATA_W = 8;
  localparam int          CLK_P  = 100;

  logic              mclk = 1'b0;
  logic              reset_n;
  logic              cfg_rx_enb;
  logic [DIV_W-1:0]  cfg_baud_16x;
  logic              cfg_pen;
  logic              cfg_epar;
  logic              rxd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              err_frame;
  logic              err_parity;
  logic              err_overrun;

  uart_rx_os16 #(
    .DIV_W  (DIV_W),
    .DATA_W (DATA_W)
  ) dut (
    .mclk         (mclk),
    .reset_n      (reset_n),
    .cfg_rx_enb   (cfg_rx_enb),
    .cfg_baud_16x (cfg_baud_16x),
    .cfg_pen      (cfg_pen),
    .cfg_epar     (cfg_epar),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .err_frame    (err_frame),
    .err_parity   (err_parity),
    .err_overrun  (err_overrun)
  );

  always #(CLK_P / 2) mclk = ~mclk;

  typedef struct {
    int         div;
    int         pct;
    bit         pen;
    bit         epar;
    logic [7:0] data;
    bit         par;
    bit         stop;
    bit         exp_ok;
    bit         exp_fe;
    bit         exp_pe;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int n_acc = 0, n_fe = 0, n_pe = 0, n_ov = 0;
  int vrun = 0, last_run = 0;
  int a0, f0, p0, o0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  vec_t vt[13];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge mclk);
  endtask

  task automatic snap();
    a0 = n_acc; f0 = n_fe; p0 = n_pe; o0 = n_ov;
  endtask

  // Monitor: error pulse counters, valid run length, scoreboard pop on accept
  always @(negedge mclk) begin
    if (reset_n) begin
      if (err_frame)   n_fe++;
      if (err_parity)  n_pe++;
      if (err_overrun) n_ov++;
      if (rx_valid) vrun++;
      else if (vrun > 0) begin
        last_run = vrun;
        vrun     = 0;
      end
      if (rx_valid && rx_ready) begin
        n_acc++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: actual=%02h required=none", rx_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (rx_data !== sb_exp) begin
            failures++;
            $display("FAIL sb_byte: actual=%02h required=%02h", rx_data, sb_exp);
          end
        end
      end
    end else begin
      vrun = 0;
    end
  end

  // Serial driver; act_kind 1 drops enable, 2 asserts reset, mid data bit act_bit
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit par, input bit stop,
                            input int bit_t, input int act_bit, input int act_kind);
    logic [10:0] fr;
    int          n;
    longint      t0;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    if (pen) begin
      fr[9]  = par;
      fr[10] = stop;
      n      = 11;
    end else begin
      fr[9] = stop;
      n     = 10;
    end
    @(posedge mclk);
    #13;
    for (int i = 0; i < n; i++) begin
      rxd = fr[i];
      if (act_kind != 0 && i == act_bit + 1) begin
        #(bit_t / 2);
        t0 = $time;
        if (act_kind == 1) begin
          cfg_rx_enb = 1'b0;
        end else begin
          reset_n = 1'b0;
          @(posedge mclk);
          #1;
          check("rst_valid", int'(rx_valid), 0);
          check("rst_data", int'(rx_data), 0);
          check("rst_errs", int'({err_frame, err_parity, err_overrun}), 0);
        end
        #(bit_t - bit_t / 2 - int'($time - t0));
      end else begin
        #(bit_t);
      end
    end
    rxd = 1'b1;
  endtask

  initial begin
    #(CLK_P * 90000);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{3,  100, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{3,  100, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{3,  100, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{3,  100, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{0,   97, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{0,   97, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{0,   97, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{0,  103, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{0,  103, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{0,  103, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[10] = '{40,  97, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[11] = '{40, 103, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[12] = '{40,  97, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    reset_n      = 1'b0;
    cfg_rx_enb   = 1'b1;
    cfg_baud_16x = DIV_W'(3);
    cfg_pen      = 1'b0;
    cfg_epar     = 1'b1;
    rxd          = 1'b1;
    rx_ready     = 1'b1;
    idle(3);
    #1;
    check("reset_valid", int'(rx_valid), 0);
    check("reset_data", int'(rx_data), 0);
    check("reset_errs", int'({err_frame, err_parity, err_overrun}), 0);
    @(posedge mclk);
    #10 reset_n = 1'b1;
    idle(10);

    // Table: basic, parity, framing and divider/rate sweep
    for (int i = 0; i < 13; i++) begin
      cfg_baud_16x = DIV_W'(vt[i].div);
      cfg_pen      = vt[i].pen;
      cfg_epar     = vt[i].epar;
      idle(5);
      snap();
      if (vt[i].exp_ok) exp_q.push_back(vt[i].data);
      send_frame(vt[i].data, vt[i].pen, vt[i].par, vt[i].stop,
                 (vt[i].div + 1) * 16 * vt[i].pct, -1, 0);
      idle(40);
      check($sformatf("v%0d_accepted", i), n_acc - a0, int'(vt[i].exp_ok));
      check($sformatf("v%0d_err_frame", i), n_fe - f0, int'(vt[i].exp_fe));
      check($sformatf("v%0d_err_parity", i), n_pe - p0, int'(vt[i].exp_pe));
      check($sformatf("v%0d_err_overrun", i), n_ov - o0, 0);
      check($sformatf("v%0d_queue", i), exp_q.size(), 0);
      if (i == 0) check("valid_width", last_run, 1);
    end

    // Short low glitch: false start, nothing reported
    cfg_baud_16x = DIV_W'(3);
    cfg_pen      = 1'b0;
    idle(5);
    snap();
    @(posedge mclk);
    #13 rxd = 1'b0;
    idle(20);
    #13 rxd = 1'b1;
    idle(100);
    check("glitch_acc", n_acc - a0, 0);
    check("glitch_errs", (n_fe - f0) + (n_pe - p0) + (n_ov - o0), 0);

    // Overrun: second byte dropped, first kept
    @(posedge mclk);
    #1 rx_ready = 1'b0;
    snap();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 4 * 16 * 100, -1, 0);
    idle(40);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 4 * 16 * 100, -1, 0);
    idle(40);
    check("ovr_pulse", n_ov - o0, 1);
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_data", int'(rx_data), 'h11);
    check("ovr_acc_held", n_acc - a0, 0);
    @(posedge mclk);
    #1 rx_ready = 1'b1;
    idle(10);
    check("ovr_acc", n_acc - a0, 1);
    check("ovr_queue", exp_q.size(), 0);
    check("ovr_valid_clr", int'(rx_valid), 0);

    // Disable during data bit 4, then a clean frame after re-enable
    snap();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 4 * 16 * 100, 4, 1);
    idle(40);
    cfg_rx_enb = 1'b1;
    idle(10);
    check("dis_acc", n_acc - a0, 0);
    check("dis_errs", (n_fe - f0) + (n_pe - p0) + (n_ov - o0), 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 4 * 16 * 100, -1, 0);
    idle(40);
    check("reen_acc", n_acc - a0, 1);
    check("reen_queue", exp_q.size(), 0);

    // Reset mid-frame with a byte held: outputs clear on the next edge
    @(posedge mclk);
    #1 rx_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 4 * 16 * 100, -1, 0);
    idle(40);
    check("pre_rst_valid", int'(rx_valid), 1);
    check("pre_rst_data", int'(rx_data), 'h5A);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 4 * 16 * 100, 3, 2);
    idle(40);
    exp_q.delete();
    @(posedge mclk);
    #10 reset_n = 1'b1;
    idle(10);
    #1 rx_ready = 1'b1;
    idle(10);
    check("post_rst_valid", int'(rx_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
